// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair; MTHI/MTLO write at the issue edge.
// Latency: long ops update HI/LO MULT_CYCLES/DIV_CYCLES+1 cycles after issue; MT ops after 1 cycle.
// Backpressure: busy is asserted combinationally at issue and held while the op counts down; requests during busy are ignored.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        dis,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;

  logic          is_mt, is_long, is_div, issue, issue_long;
  logic [63:0]   acc, prod_s, prod_u, res;
  logic signed [63:0] rs_sx, rt_sx;
  logic [31:0]   rs_mag, rt_mag, rt_mag_safe, rt_safe;
  logic [31:0]   sdiv_uq, sdiv_ur, sdiv_q, sdiv_r, udiv_q, udiv_r;

  // Decode the op class and the issue qualifier; reset suppresses any issue.
  always_comb begin
    is_mt      = (op == OP_MTHI) || (op == OP_MTLO);
    is_div     = (op == OP_DIV)  || (op == OP_DIVU);
    is_long    = (op == OP_MULT) || (op == OP_MULTU) || is_div ||
                 (op == OP_MADD) || (op == OP_MADDU) ||
                 (op == OP_MSUB) || (op == OP_MSUBU);
    issue      = start && !dis && !reset && (is_mt || is_long) && (cnt_q == '0);
    issue_long = issue && is_long;
    busy       = issue_long || (cnt_q != '0);
  end

  // Arithmetic datapath: products, accumulate base, and sign-magnitude division.
  always_comb begin
    acc    = {hi_q, lo_q};
    rs_sx  = {{32{rs[31]}}, rs};
    rt_sx  = {{32{rt[31]}}, rt};
    prod_s = 64'(rs_sx * rt_sx);
    prod_u = {32'd0, rs} * {32'd0, rt};

    // Magnitude of 0x80000000 is 0x80000000 read as unsigned, which keeps
    // the MIN/-1 case at quotient 0x80000000 after re-negation.
    rs_mag      = rs[31] ? (~rs + 32'd1) : rs;
    rt_mag      = rt[31] ? (~rt + 32'd1) : rt;
    // Divisor forced nonzero so the dividers never see /0; the result is
    // discarded in that case anyway.
    rt_mag_safe = (rt == 32'd0) ? 32'd1 : rt_mag;
    rt_safe     = (rt == 32'd0) ? 32'd1 : rt;
    sdiv_uq     = rs_mag / rt_mag_safe;
    sdiv_ur     = rs_mag % rt_mag_safe;
    sdiv_q      = (rs[31] ^ rt[31]) ? (~sdiv_uq + 32'd1) : sdiv_uq;
    sdiv_r      = rs[31] ? (~sdiv_ur + 32'd1) : sdiv_ur;
    udiv_q      = rs / rt_safe;
    udiv_r      = rs % rt_safe;

    res = acc;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_MADD:  res = acc + prod_s;
      OP_MADDU: res = acc + prod_u;
      OP_MSUB:  res = acc - prod_s;
      OP_MSUBU: res = acc - prod_u;
      OP_DIV:   res = (rt == 32'd0) ? acc : {sdiv_r, sdiv_q};
      OP_DIVU:  res = (rt == 32'd0) ? acc : {udiv_r, udiv_q};
      default:  res = acc;
    endcase
  end

  // Next-state: count down an in-flight op and commit at 1->0, else accept a new issue.
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    if (cnt_q != '0) begin
      // An in-flight op always completes; dis only gates new issue.
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d = res_hi_q;
        lo_d = res_lo_q;
      end
    end else if (issue) begin
      if (op == OP_MTHI) begin
        hi_d = rs;
      end else if (op == OP_MTLO) begin
        lo_d = rs;
      end else begin
        res_hi_d = res[63:32];
        res_lo_d = res[31:0];
        cnt_d    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end
    end
  end

  // State registers with synchronous reset that discards any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: timestamp-based reference model plus directed literals.
// Latency: model predicts busy/hi/lo every cycle from issue time + latency.
// Backpressure: requests made while the model has an op pending are expected to be ignored.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        dis = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state: architectural HI/LO and one pending result with its visibility cycle.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          pend = 1'b0;
  int          pend_done = 0;
  logic [63:0] pend_val = 64'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .dis(dis), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference result of a long op from plain 64-bit arithmetic.
  function automatic logic [63:0] model_res(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (o)
      4'd1:  return 64'(sa * sb);
      4'd2:  return 64'(ua * ub);
      4'd7:  begin p = 64'(sa * sb); return cur + p; end
      4'd8:  begin p = 64'(ua * ub); return cur + p; end
      4'd9:  begin p = 64'(sa * sb); return cur - p; end
      4'd10: begin p = 64'(ua * ub); return cur - p; end
      4'd3:  begin
               if (b == 32'd0) return cur;
               q = sa / sb; r = sa % sb;
               return {r[31:0], q[31:0]};
             end
      4'd4:  begin
               if (b == 32'd0) return cur;
               q = ua / ub; r = ua % ub;
               return {r[31:0], q[31:0]};
             end
      default: return cur;
    endcase
  endfunction

  // One cycle: drive inputs, compare DUT against model, clock, advance model.
  task automatic step(input bit r, input bit s, input logic [3:0] o,
                      input logic [31:0] a, input logic [31:0] b, input bit d);
    bit valid, long_op, iss;
    @(negedge clk);
    reset = r; start = s; op = o; rs = a; rt = b; dis = d;
    #1;
    if (pend && cyc >= pend_done) begin
      m_hi = pend_val[63:32];
      m_lo = pend_val[31:0];
      pend = 1'b0;
    end
    valid   = (o >= 4'd1) && (o <= 4'd10);
    long_op = valid && (o != 4'd5) && (o != 4'd6);
    iss     = s && !d && !r && valid && !pend;
    if (!r) chk("busy", {31'd0, busy}, {31'd0, (iss && long_op) || pend});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(posedge clk);
    if (r) begin
      m_hi = 32'd0; m_lo = 32'd0; pend = 1'b0;
    end else if (iss) begin
      if (o == 4'd5) m_hi = a;
      else if (o == 4'd6) m_lo = a;
      else begin
        pend_val  = model_res(o, a, b, {m_hi, m_lo});
        pend      = 1'b1;
        pend_done = cyc + 1 + (((o == 4'd3) || (o == 4'd4)) ? DC : MC);
      end
    end
    cyc++;
    #1;
    reset = 1'b0; start = 1'b0; dis = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // MULT -2 * 3
    step(1'b0, 1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(4);
    chk("mult_busy_c5", {31'd0, busy}, 32'd1);
    idle(1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_busy_c6", {31'd0, busy}, 32'd0);

    // MULTU then MADD
    step(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(5);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    step(1'b0, 1'b1, 4'd7, 32'd1, 32'd1, 1'b0);
    idle(5);
    chk("madd_hi", hi, 32'd1);
    chk("madd_lo", lo, 32'hFFFF_FFFF);

    // DIV -7 / 2, then DIVU by zero
    step(1'b0, 1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(9);
    chk("div_busy_c10", {31'd0, busy}, 32'd1);
    idle(1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 4'd4, 32'd7, 32'd0, 1'b0);
    idle(10);
    chk("divz_lo", lo, 32'hFFFF_FFFD);
    chk("divz_hi", hi, 32'hFFFF_FFFF);

    // MTHI, then MTHI suppressed by dis
    step(1'b0, 1'b1, 4'd5, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    step(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
    chk("mthi_dis_hi", hi, 32'h1234_5678);

    // DIV MIN / -1
    step(1'b0, 1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(10);
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 32'd0);

    // dis mid-op and ignored MULT requests while busy
    step(1'b0, 1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
    idle(3);
    chk("disdiv_lo", lo, 32'd14);
    chk("disdiv_hi", hi, 32'd2);
    idle(2);
    chk("disdiv_lo_hold", lo, 32'd14);

    // Reset in cycle 2 of a DIV
    step(1'b0, 1'b1, 4'd3, 32'd50, 32'd3, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      bit r, s, d;
      logic [3:0] o;
      r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 2) != 0);
      o = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      d = ($urandom_range(0, 7) == 0);
      step(r, s, o, pick_opnd(), pick_opnd(), d);
    end
    idle(DC + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit in the EX stage, owning the HI/LO register pair. It produces the `MDBusy` indication that the pipeline hazard controller uses to stall multiply/divide-class instructions in ID. It obeys the controller's `dis_MULTDIV` suppression so that an instruction flushed by an exception or ERET never starts or writes HI/LO. Reads (MFHI/MFLO) are served from the `hi`/`lo` outputs.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after issue for MULT/MULTU/MADD/MADDU/MSUB/MSUBU.
- `DIV_CYCLES`, default 10: busy cycles after issue for DIV/DIVU.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  EX holds a valid multdiv-class instruction this cycle.
- `op`  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11–15 treated as NONE.
- `rs`  in  32  first operand (forwarded value).
- `rt`  in  32  second operand (forwarded value).
- `dis`  in  1  `dis_MULTDIV`; suppresses issue this cycle.
- `busy`  out  1  `MDBusy`, to the pipeline controller.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- Issue condition: `issue = start & ~dis & (op != NONE) & (cnt == 0)`. If `start` is high while `cnt != 0`, the request is ignored and there is no state change. The pipeline stalls, so this case never occurs legally.
- MTHI/MTLO: when issued, `hi <= rs` (MTHI) or `lo <= rs` (MTLO) at the same edge. `cnt` is not loaded.
- Long ops: at the issue edge the unit latches the computed 64-bit result into `res_hi`/`res_lo` and loads `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - `cnt` decrements each cycle while nonzero.
  - At the edge where `cnt` goes 1→0, `hi <= res_hi` and `lo <= res_lo`.
- Multiply:
  - MULT gives the signed 32×32→64 product; MULTU gives the unsigned product. `{hi,lo} = product`.
  - MADD/MSUB: `{hi,lo} ± signed product`, using the `hi`/`lo` values at issue. Arithmetic is mod 2^64.
  - MADDU/MSUBU: the same, with an unsigned product.
- Divide:
  - DIV: `lo` = quotient truncated toward zero; `hi` = remainder, which takes the sign of the dividend (`rs`).
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives `lo=0x80000000`, `hi=0`.
  - Divide by zero (`rt==0`): the op runs its full latency, and `hi`/`lo` keep their pre-issue values at completion.
- `busy = issue_long | (cnt != 0)`, where `issue_long` is `issue` for a non-MT op. It is combinational in the issue cycle so that a dependent instruction in ID stalls immediately.
- `dis` never aborts an in-flight op. The op was committed by an older instruction, so `cnt` keeps counting and the result is written.
- Reset clears `cnt`, `hi`, `lo`, `res_hi` and `res_lo` to 0, and overrides any issue in the same cycle. Reset mid-operation discards the op.

## Timing
- Reset values: `busy=0`, `hi=0`, `lo=0`.
- For a long op issued in cycle 0:
  - `busy` is high in cycles 0..N (N = latency parameter) and low in cycle N+1.
  - `hi`/`lo` show old values through cycle N and new values from cycle N+1.
- MTHI/MTLO issued in cycle 0: `hi`/`lo` are updated in cycle 1, and `busy` stays 0 throughout.
- Back-to-back: a second long op can issue in cycle N+1, so throughput is one op per N+1 cycles.
- Simultaneous `start` and `dis`: `dis` wins, with no issue and no `busy` contribution.

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (−2), rt=3 → `busy` is 1 for cycles 0..5. In cycle 6, `hi=0xFFFFFFFF`, `lo=0xFFFFFFFA` and `busy=0`.
- MULTU rs=0xFFFFFFFF, rt=2 → after 6 cycles `hi=1`, `lo=0xFFFFFFFE`. MADD rs=1, rt=1 then gives `hi=1`, `lo=0xFFFFFFFF`.
- DIV rs=−7, rt=2 → `busy` is 1 for cycles 0..10. In cycle 11, `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. DIVU 7/0 leaves `hi`/`lo` unchanged after 11 cycles.
- MTHI rs=0x12345678 → `hi=0x12345678` next cycle with `busy` never asserted. The same op with `dis=1` leaves `hi` unchanged.
- Issue DIV, assert `dis` in cycle 3, and hold `start=1` with MULT in cycles 4–7 → DIV completes normally and the MULT requests are ignored. Then assert `reset` in cycle 2 of a new DIV → `busy=0`, `hi=lo=0` next cycle.
